// File: rtl/sobel_pkg.sv
// Shared types, error-bit indices and width helper for the Sobel frame sequencer.
package sobel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } state_e;

    localparam int ERR_CFG     = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_EXTRA   = 2;
    localparam int ERR_W       = 3;
    localparam int DATA_W      = 8;

    // Never returns 0 so that degenerate parameters still yield a legal vector.
    function automatic int width_of(input longint n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_frame_sched_if.sv
// Upstream pixel stream: valid/ready handshake with one grayscale pixel per beat.
interface sobel_frame_sched_if;
    import sobel_pkg::*;

    logic              valid;
    logic [DATA_W-1:0] pixel;
    logic              ready;

    modport master (output valid, output pixel, input ready);
    modport slave  (input valid, input pixel, output ready);
endinterface

// File: rtl/sobel_out_tagger.sv
// Registers filter outputs and tags them with row/col/SOF/EOL/EOF, counting against the frame size.
module sobel_out_tagger
    import sobel_pkg::*;
#(
    parameter int IMAGE_WIDTH = 320,
    parameter int MAX_HEIGHT  = 4095
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   clr,
    input  logic                                                   en,
    input  logic [width_of(longint'(IMAGE_WIDTH)*MAX_HEIGHT+1)-1:0] total,
    input  logic                                                   sob_out_valid,
    input  logic [DATA_W-1:0]                                      sob_out,
    output logic                                                   out_valid,
    output logic [DATA_W-1:0]                                      out_pixel,
    output logic [width_of(MAX_HEIGHT)-1:0]                        out_row,
    output logic [width_of(IMAGE_WIDTH)-1:0]                       out_col,
    output logic                                                   out_sof,
    output logic                                                   out_eol,
    output logic                                                   out_eof,
    output logic [width_of(longint'(IMAGE_WIDTH)*MAX_HEIGHT+1)-1:0] out_cnt,
    output logic                                                   extra
);
    localparam int ROW_W = width_of(MAX_HEIGHT);
    localparam int COL_W = width_of(IMAGE_WIDTH);
    localparam int CNT_W = width_of(longint'(IMAGE_WIDTH) * MAX_HEIGHT + 1);

    logic              accept;
    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] out_pixel_d, out_pixel_q;
    logic [ROW_W-1:0]  out_row_d, out_row_q, row_d, row_q;
    logic [COL_W-1:0]  out_col_d, out_col_q, col_d, col_q;
    logic              out_sof_d, out_sof_q, out_eol_d, out_eol_q, out_eof_d, out_eof_q;
    logic [CNT_W-1:0]  out_cnt_d, out_cnt_q;

    always_comb begin
        accept      = en && sob_out_valid && (out_cnt_q < total);
        extra       = en && sob_out_valid && !(out_cnt_q < total);
        out_valid_d = accept;
        out_pixel_d = out_pixel_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_sof_d   = 1'b0;
        out_eol_d   = 1'b0;
        out_eof_d   = 1'b0;
        row_d       = row_q;
        col_d       = col_q;
        out_cnt_d   = out_cnt_q;
        if (clr) begin
            row_d       = '0;
            col_d       = '0;
            out_cnt_d   = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_pixel_d = sob_out;
            out_row_d   = row_q;
            out_col_d   = col_q;
            out_sof_d   = (row_q == '0) && (col_q == '0);
            out_eol_d   = (col_q == COL_W'(IMAGE_WIDTH - 1));
            out_eof_d   = (out_cnt_q == total - CNT_W'(1));
            out_cnt_d   = out_cnt_q + CNT_W'(1);
            if (out_eol_d) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            out_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign out_cnt   = out_cnt_q;
endmodule

// File: rtl/sobel_frame_sched.sv
// Frame sequencer for sobel_basic: paced feed, zero flush, drain with timeout, tagged outputs.
module sobel_frame_sched
    import sobel_pkg::*;
#(
    parameter int IMAGE_WIDTH   = 320,
    parameter int MAX_HEIGHT    = 4095,
    parameter int GAP           = 3,
    parameter int FLUSH_PIXELS  = IMAGE_WIDTH + 2,
    parameter int DRAIN_TIMEOUT = 200000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [width_of(MAX_HEIGHT+1)-1:0]   cfg_height,
    output logic                                busy,
    output logic                                done,
    output logic [ERR_W-1:0]                    err,
    sobel_frame_sched_if.slave                  src,
    output logic                                sob_in_valid,
    output logic [DATA_W-1:0]                   sob_in,
    input  logic                                sob_out_valid,
    input  logic [DATA_W-1:0]                   sob_out,
    output logic                                out_valid,
    output logic [DATA_W-1:0]                   out_pixel,
    output logic [width_of(MAX_HEIGHT)-1:0]     out_row,
    output logic [width_of(IMAGE_WIDTH)-1:0]    out_col,
    output logic                                out_sof,
    output logic                                out_eol,
    output logic                                out_eof
);
    localparam int H_W     = width_of(MAX_HEIGHT + 1);
    localparam int CNT_W   = width_of(longint'(IMAGE_WIDTH) * MAX_HEIGHT + 1);
    localparam int GAP_W   = 4;
    localparam int FLUSH_W = width_of(FLUSH_PIXELS + 1);
    localparam int DRAIN_W = width_of(DRAIN_TIMEOUT);

    state_e             state_q;
    logic               busy_q, done_q, sob_in_valid_q;
    logic [ERR_W-1:0]   err_q;
    logic [DATA_W-1:0]  sob_in_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [CNT_W-1:0]   total_q, in_cnt_q, out_cnt;
    logic [FLUSH_W-1:0] flush_cnt_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic               cfg_ok, fire_feed, fire_flush, extra;

    assign cfg_ok     = (cfg_height >= H_W'(2)) && (cfg_height <= H_W'(MAX_HEIGHT));
    assign src.ready  = (state_q == FEED) && (gap_cnt_q == '0) && (in_cnt_q < total_q);
    assign fire_feed  = src.ready && src.valid;
    assign fire_flush = (state_q == FLUSH) && (gap_cnt_q == '0)
                        && (flush_cnt_q < FLUSH_W'(FLUSH_PIXELS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= '0;
            sob_in_valid_q <= 1'b0;
            sob_in_q       <= '0;
            gap_cnt_q      <= '0;
            total_q        <= '0;
            in_cnt_q       <= '0;
            flush_cnt_q    <= '0;
            drain_cnt_q    <= '0;
        end else begin
            done_q         <= 1'b0;
            sob_in_valid_q <= 1'b0;
            if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            // A pulse (real or flush) restarts the idle gap that follows it.
            if (fire_feed || fire_flush) begin
                sob_in_valid_q <= 1'b1;
                sob_in_q       <= fire_feed ? src.pixel : '0;
                gap_cnt_q      <= GAP_W'(GAP);
            end
            if (fire_feed) in_cnt_q <= in_cnt_q + CNT_W'(1);
            if (fire_flush) flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
            if (extra) err_q[ERR_EXTRA] <= 1'b1;

            case (state_q)
                IDLE: if (start) begin
                    in_cnt_q    <= '0;
                    flush_cnt_q <= '0;
                    drain_cnt_q <= '0;
                    gap_cnt_q   <= '0;
                    if (cfg_ok) begin
                        total_q <= CNT_W'(IMAGE_WIDTH) * CNT_W'(cfg_height);
                        err_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FEED;
                    end else begin
                        total_q <= '0;
                        err_q   <= ERR_W'(1) << ERR_CFG;
                        state_q <= DONE;
                    end
                end
                FEED: if (in_cnt_q == total_q) state_q <= FLUSH;
                FLUSH: if (flush_cnt_q == FLUSH_W'(FLUSH_PIXELS)) begin
                    drain_cnt_q <= '0;
                    state_q     <= DRAIN;
                end
                DRAIN: begin
                    if (out_cnt == total_q) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (drain_cnt_q == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
                        err_q[ERR_TIMEOUT] <= 1'b1;
                        busy_q             <= 1'b0;
                        state_q            <= DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sobel_out_tagger #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .MAX_HEIGHT  (MAX_HEIGHT)
    ) u_tagger (
        .clk           (clk),
        .rst           (rst),
        .clr           (start && (state_q == IDLE)),
        .en            (state_q != IDLE),
        .total         (total_q),
        .sob_out_valid (sob_out_valid),
        .sob_out       (sob_out),
        .out_valid     (out_valid),
        .out_pixel     (out_pixel),
        .out_row       (out_row),
        .out_col       (out_col),
        .out_sof       (out_sof),
        .out_eol       (out_eol),
        .out_eof       (out_eof),
        .out_cnt       (out_cnt),
        .extra         (extra)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign sob_in_valid = sob_in_valid_q;
    assign sob_in       = sob_in_q;
endmodule

// File: tb/tb_sobel_frame_sched.sv
// Directed bench for sobel_frame_sched with a stub filter and queue-based scoreboards.
module tb_sobel_frame_sched;
    import sobel_pkg::*;

    localparam int W     = 8;
    localparam int GAP   = 3;
    localparam int FLUSH = W + 2;
    localparam int DTO   = 50;
    localparam int MAXH  = 4095;
    localparam int HW    = width_of(MAXH + 1);
    localparam int RW    = width_of(MAXH);
    localparam int CW    = width_of(W);
    localparam int BOUND = 3000;

    typedef struct { logic [7:0] val; int cyc; } pulse_t;
    typedef struct { logic [7:0] pix; int row; int col; logic sof; logic eol; logic eof; } tag_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [HW-1:0] cfg_height = '0;
    logic          busy, done, sob_in_valid, out_valid, out_sof, out_eol, out_eof;
    logic [2:0]    err;
    logic [7:0]    sob_in, out_pixel;
    logic          sob_out_valid = 1'b0;
    logic [7:0]    sob_out = '0;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    sobel_frame_sched_if src_if ();

    sobel_frame_sched #(
        .IMAGE_WIDTH(W), .MAX_HEIGHT(MAXH), .GAP(GAP), .FLUSH_PIXELS(FLUSH), .DRAIN_TIMEOUT(DTO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_height(cfg_height), .busy(busy), .done(done),
        .err(err), .src(src_if), .sob_in_valid(sob_in_valid), .sob_in(sob_in),
        .sob_out_valid(sob_out_valid), .sob_out(sob_out), .out_valid(out_valid),
        .out_pixel(out_pixel), .out_row(out_row), .out_col(out_col), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    pulse_t pulse_q[$];
    tag_t   tag_q[$];
    pulse_t pe;
    tag_t   te;
    int stub_in_cnt = 0, stub_out_cnt = 0, stub_skip = 0, stub_limit = 0, frame_total = 0;
    int pulse_cnt = 0, out_seen = 0, last_pulse_cyc = 0, done_cnt = 0, done_cyc = 0;
    bit strict_gap = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stub_val(input int j);
        return 8'((j * 37 + 5) % 256);
    endfunction

    function automatic tag_t exp_tag(input int j);
        tag_t t;
        t.pix = stub_val(j);
        t.row = j / W;
        t.col = j % W;
        t.sof = (j == 0);
        t.eol = ((j % W) == W - 1);
        t.eof = (j == frame_total - 1);
        return t;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Stub filter: swallows the first stub_skip pulses, then echoes one output per pulse up to stub_limit.
    always @(negedge clk) begin
        sob_out_valid = 1'b0;
        if (!rst && sob_in_valid) begin
            if (stub_in_cnt >= stub_skip && stub_out_cnt < stub_limit) begin
                sob_out_valid = 1'b1;
                sob_out = stub_val(stub_out_cnt);
                if (stub_out_cnt < frame_total) tag_q.push_back(exp_tag(stub_out_cnt));
                stub_out_cnt++;
            end
            stub_in_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (src_if.ready && pulse_cnt > 0)
                check("ready_in_gap", 32'(cyc - last_pulse_cyc >= GAP), 32'd1);
            if (sob_in_valid) begin
                pulse_cnt++;
                if (pulse_cnt > 1) begin
                    if (strict_gap) check("pulse_spacing", cyc - last_pulse_cyc, GAP + 1);
                    else check("pulse_spacing_min", 32'(cyc - last_pulse_cyc >= GAP + 1), 32'd1);
                end
                if (pulse_q.size() > 0) begin
                    pe = pulse_q.pop_front();
                    check("pulse_value", sob_in, pe.val);
                    check("pulse_cycle", cyc, pe.cyc);
                end else begin
                    check("flush_value", sob_in, 8'd0);
                end
                last_pulse_cyc = cyc;
            end else if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
                check("pulse_missing", sob_in_valid, 1'b1);
                void'(pulse_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            out_seen++;
            if (tag_q.size() == 0) begin
                check("out_unexpected", out_valid, 1'b0);
            end else begin
                te = tag_q.pop_front();
                check("out_pixel", out_pixel, te.pix);
                check("out_row", out_row, te.row);
                check("out_col", out_col, te.col);
                check("out_sof", out_sof, te.sof);
                check("out_eol", out_eol, te.eol);
                check("out_eof", out_eof, te.eof);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic run_frame(input int h, input int base, input int period, input bit strict,
                             input int skip, input int limit, input int abort_after,
                             input logic [2:0] exp_err, input int exp_pulses, input int exp_outs);
        int d0, n, start_cyc;
        logic [7:0] pix;
        pulse_q.delete();
        tag_q.delete();
        stub_in_cnt = 0; stub_out_cnt = 0; stub_skip = skip; stub_limit = limit;
        frame_total = W * h; pulse_cnt = 0; out_seen = 0; strict_gap = strict;
        d0 = done_cnt; n = 0; pix = 8'(base);
        @(negedge clk); #1;
        start = 1'b1; cfg_height = HW'(h); start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < BOUND && done_cnt == d0; t++) begin
            if (abort_after > 0 && pulse_cnt >= abort_after) break;
            src_if.valid = (n < W * h) && (t % period == 0);
            src_if.pixel = pix;
            if (src_if.valid && src_if.ready) begin
                pulse_q.push_back('{pix, cyc + 1});
                pix = pix + 8'd1;
                n++;
            end
            @(negedge clk); #1;
        end
        src_if.valid = 1'b0;
        if (abort_after > 0) begin
            rst = 1'b1;
            pulse_q.delete();
            d0 = done_cnt;
            @(negedge clk); #1;
            check("abort_sob_in_valid", sob_in_valid, 1'b0);
            check("abort_out_valid", out_valid, 1'b0);
            check("abort_busy", busy, 1'b0);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            #1;
            check("abort_no_done", done_cnt - d0, 0);
            return;
        end
        check("done_seen", done_cnt - d0, 1);
        check("busy_at_done", busy, 1'b0);
        check("err", err, exp_err);
        if (exp_err[ERR_CFG]) check("cfg_done_latency", done_cyc - start_cyc, 2);
        // DRAIN starts the cycle after the last flush pulse, lasts DTO cycles, then DONE precedes done.
        if (exp_err[ERR_TIMEOUT]) check("drain_timeout_latency", done_cyc - last_pulse_cyc, DTO + 2);
        repeat (3) @(negedge clk);
        #1;
        check("single_done", done_cnt - d0, 1);
        check("pulse_count", pulse_cnt, exp_pulses);
        check("out_count", out_seen, exp_outs);
        check("tags_left", tag_q.size(), 0);
        check("pulses_left", pulse_q.size(), 0);
        check("err_held", err, exp_err);
    endtask

    initial begin
        src_if.valid = 1'b0;
        src_if.pixel = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 3'b000);
        check("rst_src_ready", src_if.ready, 1'b0);
        check("rst_sob_in_valid", sob_in_valid, 1'b0);
        check("rst_sob_in", sob_in, 8'd0);
        check("rst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(4, 0, 1, 1'b1, W + 2, 1000, 0, 3'b000, W * 4 + FLUSH, W * 4);
        run_frame(4, 100, 7, 1'b0, W + 2, 1000, 0, 3'b000, W * 4 + FLUSH, W * 4);
        run_frame(1, 0, 1, 1'b0, W + 2, 1000, 0, 3'b001, 0, 0);
        run_frame(0, 0, 1, 1'b0, W + 2, 1000, 0, 3'b001, 0, 0);
        run_frame(4, 50, 1, 1'b1, W + 2, 20, 0, 3'b010, W * 4 + FLUSH, 20);
        run_frame(4, 7, 1, 1'b1, W + 1, 1000, 0, 3'b100, W * 4 + FLUSH, W * 4);
        run_frame(4, 0, 1, 1'b1, W + 2, 1000, 10, 3'b000, 0, 0);
        run_frame(2, 200, 1, 1'b1, W + 2, 1000, 0, 3'b000, W * 2 + FLUSH, W * 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
